// File: rtl/inj_gate_sequencer_pkg.sv
// inj_seq_pkg: shared state type and constants for the injection/gate sequencer
package inj_seq_pkg;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_PRE_WIDTH = 8;
  localparam int MIN_LOW = 1;
  typedef enum logic [2:0] {IDLE, PRE, PULSE, LOW, HOLD, POST, FINISH} seq_state_t;
endpackage

// File: rtl/inj_gate_sequencer_if.sv
// inj_gate_sequencer_if: control, configuration and status bundle of the sequencer
interface inj_gate_sequencer_if
  import inj_seq_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
);
  logic START;
  logic ABORT;
  logic [CNT_WIDTH-1:0] CONF_INJ_COUNT;
  logic [CNT_WIDTH-1:0] CONF_INJ_PERIOD;
  logic [CNT_WIDTH-1:0] CONF_INJ_WIDTH;
  logic [PRE_WIDTH-1:0] CONF_GATE_PRE;
  logic [CNT_WIDTH-1:0] CONF_GATE_POST;
  logic FIFO_NEAR_FULL;
  logic INJECTION;
  logic GATE_TDC;
  logic BUSY;
  logic DONE;
  logic [CNT_WIDTH-1:0] INJ_CNT;
  modport master (
    output START, ABORT, CONF_INJ_COUNT, CONF_INJ_PERIOD, CONF_INJ_WIDTH, CONF_GATE_PRE,
           CONF_GATE_POST, FIFO_NEAR_FULL,
    input  INJECTION, GATE_TDC, BUSY, DONE, INJ_CNT
  );
  modport slave (
    input  START, ABORT, CONF_INJ_COUNT, CONF_INJ_PERIOD, CONF_INJ_WIDTH, CONF_GATE_PRE,
           CONF_GATE_POST, FIFO_NEAR_FULL,
    output INJECTION, GATE_TDC, BUSY, DONE, INJ_CNT
  );
endinterface

// File: rtl/inj_gate_sequencer.sv
// inj_gate_sequencer: bursts of injection pulses inside a TDC gate window, throttled by FIFO back-pressure
module inj_gate_sequencer
  import inj_seq_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input logic CLK40,
  input logic nRST,
  inj_gate_sequencer_if.slave bus
);
  seq_state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, w_m1, low_m1, lim, post, inj_cnt_n;
  logic [CNT_WIDTH-1:0] cw, cw_m1, cl;
  logic [CNT_WIDTH:0] cw1, cp;
  logic last, inj_d, gate_d, done_d;
  // effective width/low time derived from the live configuration, latched on START
  always_comb begin
    cw = (bus.CONF_INJ_WIDTH == '0) ? CNT_WIDTH'(1) : bus.CONF_INJ_WIDTH;
    cw_m1 = cw - 1'b1;
    cw1 = {1'b0, cw} + (CNT_WIDTH+1)'(MIN_LOW);
    cp = ({1'b0, bus.CONF_INJ_PERIOD} < cw1) ? cw1 : {1'b0, bus.CONF_INJ_PERIOD};
    cl = CNT_WIDTH'(cp - cw1);
  end
  // state, duration counter, shadow configuration and registered outputs
  always_ff @(posedge CLK40) begin
    if (!nRST) begin
      state <= IDLE;
      cnt <= '0;
      bus.INJECTION <= 1'b0;
      bus.GATE_TDC <= 1'b0;
      bus.BUSY <= 1'b0;
      bus.DONE <= 1'b0;
      bus.INJ_CNT <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.INJECTION <= inj_d;
      bus.GATE_TDC <= gate_d;
      bus.BUSY <= gate_d;
      bus.DONE <= done_d;
      bus.INJ_CNT <= inj_cnt_n;
      if (state == IDLE && bus.START) begin
        w_m1 <= cw_m1;
        low_m1 <= cl;
        lim <= bus.CONF_INJ_COUNT;
        post <= bus.CONF_GATE_POST;
      end
    end
  end
  // next state, counter reload on every state entry, pulse count
  always_comb begin
    last = cnt == '0;
    state_n = state;
    case (state)
      IDLE: if (bus.START) state_n = (bus.CONF_GATE_PRE != '0) ? PRE : PULSE;
      PRE: if (last) state_n = PULSE;
      PULSE: if (last) state_n = (lim != '0 && bus.INJ_CNT == lim) ? ((post != '0) ? POST : FINISH) : LOW;
      LOW: if (last) state_n = bus.FIFO_NEAR_FULL ? HOLD : PULSE;
      HOLD: if (!bus.FIFO_NEAR_FULL) state_n = PULSE;
      POST: if (last) state_n = FINISH;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && bus.ABORT) state_n = IDLE;
    cnt_n = last ? cnt : cnt - 1'b1;
    if (state_n != state)
      cnt_n = (state_n == PRE) ? CNT_WIDTH'(bus.CONF_GATE_PRE) - 1'b1 :
              (state_n == PULSE) ? ((state == IDLE) ? cw_m1 : w_m1) :
              (state_n == LOW) ? low_m1 :
              (state_n == POST) ? post - 1'b1 : '0;
    inj_cnt_n = ((state == IDLE && state_n != IDLE) ? '0 : bus.INJ_CNT)
              + CNT_WIDTH'(state_n == PULSE && state != PULSE);
  end
  // output decode of the upcoming state
  always_comb begin
    inj_d = state_n == PULSE;
    gate_d = state_n inside {PRE, PULSE, LOW, HOLD, POST};
    done_d = state_n == FINISH;
  end
endmodule

// File: doc/inj_gate_sequencer.md
Name: inj_gate_sequencer

Overview:
Sequences the injection pulse and the TDC/timestamp gate window for charge-injection scans. It produces a programmable burst of INJECTION pulses inside a GATE_TDC window. It throttles the burst while the readout FIFO is near full, so that timestamp and hit data are never vetoed mid-scan. It sits in the core beside the injection pulse generator, is driven from register-block configuration, and runs in the CLK40 domain.

Parameters:
CNT_WIDTH, 16, width of the count, period, width and post-gate fields and of INJ_CNT.
PRE_WIDTH, 8, width of the GATE_PRE field.

Ports:
CLK40  input  1  sequencer clock, 40 MHz.
nRST  input  1  reset; synchronous, active-low.
START  input  1  single-cycle start request; honoured only in IDLE.
ABORT  input  1  single-cycle abort request; honoured in any non-IDLE state.
CONF_INJ_COUNT  input  CNT_WIDTH  pulses per burst; 0 = run until ABORT.
CONF_INJ_PERIOD  input  CNT_WIDTH  cycles from one INJECTION rise to the next.
CONF_INJ_WIDTH  input  CNT_WIDTH  INJECTION high time in cycles.
CONF_GATE_PRE  input  PRE_WIDTH  gate-open cycles before the first pulse.
CONF_GATE_POST  input  CNT_WIDTH  gate-open cycles after the last pulse falls.
FIFO_NEAR_FULL  input  1  readout back-pressure.
INJECTION  output  1  registered injection pulse.
GATE_TDC  output  1  registered gate window for the timestamp/TDC EXT_ENABLE.
BUSY  output  1  high while a burst is in progress.
DONE  output  1  one-cycle pulse on normal completion.
INJ_CNT  output  CNT_WIDTH  pulses issued in the current or last burst.

Behaviour:
- Reset (nRST=0 at a CLK40 edge): state IDLE; INJECTION=0, GATE_TDC=0, BUSY=0, DONE=0, INJ_CNT=0. Reset overrides START and ABORT and aborts any burst immediately.
- All CONF_* inputs are latched into shadow registers on the accepted START edge. Changes during a burst are ignored.
- Effective width W = max(CONF_INJ_WIDTH, 1).
- Effective period P = max(CONF_INJ_PERIOD, W+1), which guarantees at least one low cycle between pulses.
- All outputs are registered. Output changes are visible on the edge after the state decision.
- States and transitions:
  - IDLE: START=1 -> PRE, or -> PULSE if GATE_PRE=0. INJ_CNT is cleared to 0 at the same edge.
  - PRE: GATE_TDC=1, lasting GATE_PRE cycles -> PULSE.
  - PULSE: INJECTION=1 for W cycles. INJ_CNT increments on the entry edge. At exit:
    - if INJ_COUNT!=0 and INJ_CNT==INJ_COUNT -> POST, or -> FINISH if GATE_POST=0;
    - otherwise -> LOW.
  - LOW: INJECTION=0 for P-W cycles. At exit, FIFO_NEAR_FULL=1 -> HOLD, otherwise -> PULSE.
  - HOLD: gate stays open, INJECTION=0. In the first cycle FIFO_NEAR_FULL is sampled 0 -> PULSE at the next edge. The period is stretched and no pulse is dropped.
  - POST: GATE_TDC=1 for GATE_POST cycles -> FINISH.
  - FINISH: GATE_TDC=0, BUSY=0, DONE=1 for one cycle -> IDLE.
- BUSY=1 in PRE, PULSE, LOW, HOLD and POST. GATE_TDC=1 in the same states.
- ABORT in any non-IDLE state:
  - next edge: INJECTION=0, GATE_TDC=0, BUSY=0, state IDLE;
  - DONE is not pulsed and INJ_CNT holds its value.
  - ABORT and START in the same cycle: ABORT has priority in non-IDLE states. In IDLE, START wins and ABORT is ignored.
- START while BUSY is ignored and causes no restart.
- INJ_COUNT=0 runs until ABORT. INJ_CNT wraps modulo 2^CNT_WIDTH and the wrap has no effect on sequencing.
- FIFO_NEAR_FULL is ignored in PRE, PULSE and POST. A pulse that has started always completes its W cycles.
- One down-counter of CNT_WIDTH bits is reloaded on each state entry. State durations are exact cycle counts.

Decomposition:
- Shared package inj_seq_pkg holds:
  - the state enum (IDLE, PRE, PULSE, LOW, HOLD, POST, FINISH);
  - the CNT_WIDTH and PRE_WIDTH defaults;
  - the minimum-low-cycle constant (1).
- Single module, no sub-module. A register wrapper with BUS_CLK-to-CLK40 synchronisation of the CONF_* fields and START/ABORT is a separate later block and is not part of this one.

Test Plan:
- Basic burst, START at cycle 0 with COUNT=2, PERIOD=8, WIDTH=3, PRE=2, POST=4 -> GATE_TDC high cycles 1-17; INJECTION high 3-5 and 11-13; BUSY high 1-17; DONE=1 at cycle 18 only; INJ_CNT=2.
- Clamping, PERIOD=2, WIDTH=0, COUNT=3, PRE=0, POST=0 -> INJECTION high 1 cycle, low 1 cycle, for 3 pulses; DONE 6 cycles after START.
- Back-pressure, same config as the first scenario with FIFO_NEAR_FULL=1 during cycles 8-15 -> second pulse starts at cycle 17 instead of 11; gate stays open throughout the hold; INJ_CNT=2.
- ABORT, COUNT=0, PERIOD=10, ABORT asserted during the 5th pulse -> INJECTION and GATE_TDC low the next cycle; no DONE; INJ_CNT=5; a START asserted in the ABORT cycle is ignored.
- Reset mid-burst, nRST=0 for 1 cycle while in LOW -> all outputs 0 at the next edge; state IDLE; a subsequent START gives a clean burst with INJ_CNT starting from 1.
- Shadowing, CONF_INJ_WIDTH changed from 3 to 7 mid-burst -> all pulses in the burst remain 3 cycles wide.
